// File: rtl/axi_lite_fifo_slave_pkg.sv
// Shared types and constants for the AXI4-Lite FIFO slave: response codes,
// register offsets and the STATUS register layout.
package axi_lite_fifo_slave_pkg;

  // Widest-case containers; modules slice these to their parameter widths.
  typedef logic [31:0] addr_t;
  typedef logic [63:0] data_t;
  typedef logic [7:0]  strb_t;
  typedef logic [1:0]  resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  localparam logic [7:0] REG_TXDATA = 8'h00;
  localparam logic [7:0] REG_RXDATA = 8'h04;
  localparam logic [7:0] REG_STATUS = 8'h08;
  localparam logic [7:0] REG_CTRL   = 8'h0C;

  typedef struct packed {
    logic [7:0] rsvd_hi;
    logic [7:0] rx_count;
    logic [7:0] tx_count;
    logic [2:0] rsvd_lo;
    logic       irq;
    logic       rx_empty;
    logic       rx_full;
    logic       tx_empty;
    logic       tx_full;
  } status_t;

endpackage

// File: rtl/axi_lite_fifo_slave_sync_fifo.sv
// Single-clock first-word fall-through FIFO with flush; flush wins over
// any same-cycle push or pop. Storage is not reset, only pointers/count.
module axi_lite_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/axi_lite_fifo_slave.sv
// AXI4-Lite slave bridging register accesses to a TX and an RX FIFO.
// Optional interrupt output enabled by defining AXI_LITE_FIFO_IRQ_EN.
module axi_lite_fifo_slave
  import axi_lite_fifo_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready
`ifdef AXI_LITE_FIFO_IRQ_EN
  ,
  output logic                    irq
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                  tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0]         tx_count, rx_count;
  logic [DATA_WIDTH-1:0] tx_head, rx_head;
  logic                  tx_push, rx_pop, ctrl_wr;
  logic                  wr_hs, rd_hs;
  logic [ADDR_WIDTH-1:0] aw_word, ar_word;

  logic                  bvalid_q, rvalid_q;
  resp_t                 bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, ctrl_rd;
  logic                  tx_flush_q, rx_flush_q;
  status_t               status;
  logic                  irq_bit;

  logic unused_bits;
  assign unused_bits = ^{AWADDR[1:0], ARADDR[1:0], WSTRB[DATA_WIDTH/8-1:1]};

  // Byte-lane bits of the address are ignored by forcing them to zero.
  assign aw_word = {AWADDR[ADDR_WIDTH-1:2], 2'b00};
  assign ar_word = {ARADDR[ADDR_WIDTH-1:2], 2'b00};

  assign wr_hs   = AWVALID & WVALID & ~bvalid_q & ~ARESET;
  assign rd_hs   = ARVALID & ~rvalid_q & ~ARESET;
  assign AWREADY = wr_hs;
  assign WREADY  = wr_hs;
  assign ARREADY = rd_hs;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign RVALID  = rvalid_q;
  assign RRESP   = rresp_q;
  assign RDATA   = rdata_q;

  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_empty ? '0 : tx_head;
  assign rx_ready = ~rx_full & ~ARESET;

  always_comb begin
    bresp_d = RESP_OKAY;
    tx_push = 1'b0;
    ctrl_wr = 1'b0;
    if (aw_word == ADDR_WIDTH'(REG_TXDATA)) begin
      if (tx_full) bresp_d = RESP_SLVERR;
      else         tx_push = wr_hs;
    end else if (aw_word == ADDR_WIDTH'(REG_CTRL)) begin
      ctrl_wr = wr_hs & WSTRB[0];
    end else if (aw_word == ADDR_WIDTH'(REG_STATUS) || aw_word == ADDR_WIDTH'(REG_RXDATA)) begin
      bresp_d = RESP_SLVERR;
    end else begin
      bresp_d = RESP_DECERR;
    end
  end

  always_comb begin
    status          = '0;
    status.tx_full  = tx_full;
    status.tx_empty = tx_empty;
    status.rx_full  = rx_full;
    status.rx_empty = rx_empty;
    status.tx_count = 8'(tx_count);
    status.rx_count = 8'(rx_count);
    status.irq      = irq_bit;
  end

  always_comb begin
    rdata_d = '0;
    rresp_d = RESP_OKAY;
    rx_pop  = 1'b0;
    if (ar_word == ADDR_WIDTH'(REG_RXDATA)) begin
      if (rx_empty) begin
        rresp_d = RESP_SLVERR;
      end else begin
        rdata_d = rx_head;
        rx_pop  = rd_hs;
      end
    end else if (ar_word == ADDR_WIDTH'(REG_STATUS)) begin
      rdata_d = DATA_WIDTH'(status);
    end else if (ar_word == ADDR_WIDTH'(REG_CTRL)) begin
      rdata_d = ctrl_rd;
    end else if (ar_word == ADDR_WIDTH'(REG_TXDATA)) begin
      rresp_d = RESP_SLVERR;
    end else begin
      rresp_d = RESP_DECERR;
    end
  end

  // Flush requests are registered so the FIFO empties on the edge after the
  // CTRL write handshake; they self-clear one cycle later.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      tx_flush_q <= 1'b0;
      rx_flush_q <= 1'b0;
    end else begin
      if (wr_hs) begin
        bvalid_q <= 1'b1;
        bresp_q  <= bresp_d;
      end else if (BREADY) begin
        bvalid_q <= 1'b0;
      end
      if (rd_hs) begin
        rvalid_q <= 1'b1;
        rresp_q  <= rresp_d;
        rdata_q  <= rdata_d;
      end else if (RREADY) begin
        rvalid_q <= 1'b0;
      end
      tx_flush_q <= ctrl_wr & WDATA[0];
      rx_flush_q <= ctrl_wr & WDATA[1];
    end
  end

`ifdef AXI_LITE_FIFO_IRQ_EN
  logic [1:0] irq_en_q;  // [1] tx_empty enable, [0] rx_nonempty enable
  logic       irq_q;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      irq_en_q <= 2'b00;
      irq_q    <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en_q <= WDATA[9:8];
      irq_q <= (irq_en_q[0] & ~rx_empty) | (irq_en_q[1] & tx_empty);
    end
  end

  assign irq     = irq_q;
  assign irq_bit = irq_q;
  always_comb begin
    ctrl_rd      = '0;
    ctrl_rd[9:8] = irq_en_q;
  end
`else
  assign irq_bit = 1'b0;
  assign ctrl_rd = '0;
`endif

  axi_lite_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (ACLK),
    .rst   (ARESET),
    .push  (tx_push),
    .pop   (tx_valid & tx_ready),
    .flush (tx_flush_q),
    .din   (WDATA),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  axi_lite_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (ACLK),
    .rst   (ARESET),
    .push  (rx_valid & ~rx_full),
    .pop   (rx_pop),
    .flush (rx_flush_q),
    .din   (rx_data),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

endmodule

// File: doc/axi_lite_fifo_slave.md
Name: axi_lite_fifo_slave

Overview:
- Parametrised AXI4-Lite slave that bridges register accesses to two on-chip FIFOs.
- TX direction: AXI writes push into the TX FIFO, which drains to a user-side valid/ready stream.
- RX direction: a user-side stream fills the RX FIFO, which AXI reads pop.
- Successor to the fixed-width AXI-Lite interface. Adds width/depth parametrisation, status/control registers, error responses and per-FIFO flush. Sits between the system interconnect and a streaming peripheral.

Parameters:
- ADDR_WIDTH, 32, AXI address width (>=4).
- DATA_WIDTH, 32, AXI/stream data width (32 or 64).
- FIFO_DEPTH, 16, entries per FIFO; power of 2, 2..128.

Ports:
- ACLK  in  1  clock, all logic rising-edge.
- ARESET  in  1  asynchronous, active-high reset.
- AWADDR  in  ADDR_WIDTH  write address.
- AWVALID  in  1 / AWREADY  out  1  write-address handshake.
- WDATA  in  DATA_WIDTH  write data.
- WSTRB  in  DATA_WIDTH/8  byte strobes.
- WVALID  in  1 / WREADY  out  1  write-data handshake.
- BRESP  out  2  write response.
- BVALID  out  1 / BREADY  in  1  write-response handshake.
- ARADDR  in  ADDR_WIDTH  read address.
- ARVALID  in  1 / ARREADY  out  1  read-address handshake.
- RDATA  out  DATA_WIDTH  read data.
- RRESP  out  2  read response.
- RVALID  out  1 / RREADY  in  1  read-data handshake.
- tx_data  out  DATA_WIDTH / tx_valid  out  1 / tx_ready  in  1  TX stream out.
- rx_data  in  DATA_WIDTH / rx_valid  in  1 / rx_ready  out  1  RX stream in.

Behaviour:
- Reset: every output is 0; both FIFOs are empty; CTRL is 0.
- Register map, decoded on ADDR[ADDR_WIDTH-1:2]; ADDR[1:0] is ignored:
  - 0x0 TXDATA (W): push.
  - 0x4 RXDATA (R): pop.
  - 0x8 STATUS (R): bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty, [15:8] tx_count, [23:16] rx_count, rest 0.
  - 0xC CTRL (R/W): bit0 tx_flush, bit1 rx_flush (both self-clearing, read 0), bits[7:2] reserved.
- Write channel:
  - AWREADY=WREADY=1 for one cycle only when AWVALID&WVALID&!BVALID.
  - The write takes effect on that edge; BVALID rises the next cycle and holds with stable BRESP until BREADY.
  - One outstanding write at a time. AW without W, or W without AW, waits.
- Read channel:
  - ARREADY=1 for one cycle when ARVALID&!RVALID.
  - RDATA/RRESP are registered and RVALID rises the next cycle, held until RREADY.
  - A pop occurs at the AR handshake, not at the R handshake.
- Responses:
  - OKAY=00.
  - TXDATA write while tx_count==FIFO_DEPTH: SLVERR=10, data dropped.
  - RXDATA read while rx empty: SLVERR, RDATA=0.
  - Offset beyond 0xC: DECERR=11, no side effect, RDATA=0.
  - Write to STATUS or read of TXDATA: SLVERR, no side effect.
- WSTRB: ignored for TXDATA (the full word is pushed). CTRL bits apply only when WSTRB[0]=1.
- Full/empty tests use the count at the handshake edge. A simultaneous stream pop does not make room for the same-cycle push.
- Counts: count_next = count + push - pop; simultaneous push and pop leaves the count unchanged.
- Stream side:
  - tx_valid = !tx_empty; tx_data is the head entry (first-word fall-through).
  - rx_ready = !rx_full; rx_valid&rx_ready pushes rx_data.
- Flush:
  - Empties the FIFO on the edge after the CTRL write handshake.
  - A same-cycle stream push/pop on that FIFO is discarded.
  - Flush wins over any same-cycle stream activity.
- Pointers: log2(FIFO_DEPTH) bits wide, wrapping naturally. Count is log2(FIFO_DEPTH)+1 bits.
- ARESET mid-transaction aborts it immediately: BVALID/RVALID drop and FIFO contents are lost.

Optional Feature:
- Macro AXI_LITE_FIFO_IRQ_EN. When defined:
  - Adds output irq (1 bit) and CTRL bits [9:8] irq_en_rx_nonempty / irq_en_tx_empty.
  - irq is registered: irq = (en_rx & !rx_empty) | (en_tx & tx_empty). Reset value 0.
  - STATUS bit4 mirrors irq.
- When undefined: no irq port, CTRL[9:8] reads 0, STATUS bit4 = 0.

Decomposition:
- AXI_Lite_Package gains:
  - Response constants RESP_OKAY/RESP_SLVERR/RESP_DECERR.
  - Register offset constants REG_TXDATA/REG_RXDATA/REG_STATUS/REG_CTRL.
  - A STATUS bit-field struct.
- The existing addr_t/data_t/strb_t/resp_t types are reused.
- One sub-module: axi_lite_sync_fifo.
  - Parameters: width and depth. Ports: push, pop, flush, full, empty, count.
  - Instantiated twice, for TX and RX.

Test Plan (all with FIFO_DEPTH=4):
- Reset, then read STATUS -> 0x0000_000A (tx_empty, rx_empty), RRESP=00, tx_valid=0, rx_ready=1.
- Hold tx_ready=0, write TXDATA 0x11,0x22,0x33,0x44,0x55 -> four OKAY then SLVERR; STATUS[15:8]=4, bit0=1; then tx_ready=1 -> tx_data 0x11,0x22,0x33,0x44 in order.
- Stream rx 0xA0..0xA4 with rx_valid=1 -> rx_ready drops after 4 accepted. Read RXDATA 5 times -> 0xA0..0xA3 OKAY, then RDATA=0 SLVERR.
- With 2 TX entries, write CTRL=0x1 -> BRESP=00, next cycle tx_valid=0, STATUS[15:8]=0; CTRL reads back 0.
- Read 0x10 and write 0x14 -> DECERR on both, no FIFO change. Write STATUS -> SLVERR.
- BREADY held low 5 cycles after a write -> BVALID and BRESP stable, AWREADY stays 0 for a queued second write. Assert ARESET mid-hold -> BVALID=0 immediately.
